// File: rtl/psum_pkg.sv
// psum_pkg: shared types and constants for the partial-sum accumulator.
// Optional feature macro: PSUM_SAT_EN (signed-saturating adds, sat_flag port).
package psum_pkg;

    localparam int DATA_BITWIDTH = 16;
    localparam int CNT_BITWIDTH  = 8;

    // Saturation limits for the signed result
    localparam logic [DATA_BITWIDTH-1:0] SAT_MAX =
        {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
    localparam logic [DATA_BITWIDTH-1:0] SAT_MIN =
        {1'b1, {(DATA_BITWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/psum_acc_adder2.sv
// adder2: plain two-input wrapping adder shared by the accumulator.
// Overflow handling lives in the caller.
module adder2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] left,
    input  logic [W-1:0] right,
    output logic [W-1:0] sum
);

    // Modulo-2^W sum
    always_comb begin
        sum = left + right;
    end

endmodule

// File: rtl/psum_acc.sv
// psum_acc: reduces every cfg_len accepted beats into one result, valid/ready on both sides.
// Optional feature macro: PSUM_SAT_EN (signed saturation plus sat_flag output).
module psum_acc
    import psum_pkg::*;
#(
    parameter int DATA_BITWIDTH = psum_pkg::DATA_BITWIDTH,
    parameter int CNT_BITWIDTH  = psum_pkg::CNT_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CNT_BITWIDTH-1:0]  cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     busy
`ifdef PSUM_SAT_EN
    ,
    output logic                     sat_flag
`endif
);

    state_t                    state_q, state_d;
    logic [DATA_BITWIDTH-1:0]  acc_q, acc_d;
    logic [CNT_BITWIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_BITWIDTH-1:0]   len_q, len_d;
    logic [DATA_BITWIDTH-1:0]  sum_raw;
    logic [DATA_BITWIDTH-1:0]  acc_sum;
    logic [CNT_BITWIDTH-1:0]   cnt_inc;
    logic [CNT_BITWIDTH-1:0]   len_eff;
    logic                      accept;

    adder2 #(
        .W(DATA_BITWIDTH)
    ) u_adder2 (
        .left (acc_q),
        .right(in_data),
        .sum  (sum_raw)
    );

`ifdef PSUM_SAT_EN
    logic sat_q, sat_d;
    logic ovf;

    // Signed overflow: equal operand signs, result sign differs
    always_comb begin
        ovf = (acc_q[DATA_BITWIDTH-1] == in_data[DATA_BITWIDTH-1]) &&
              (sum_raw[DATA_BITWIDTH-1] != acc_q[DATA_BITWIDTH-1]);
        if (ovf) begin
            acc_sum = acc_q[DATA_BITWIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            acc_sum = sum_raw;
        end
    end
`else
    // Wrap-around accumulation straight from the adder
    always_comb begin
        acc_sum = sum_raw;
    end
`endif

    // Handshake decode from registered state only
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_data  = acc_q;
        busy      = (state_q != IDLE);
        accept    = in_valid && in_ready;
        cnt_inc   = cnt_q + CNT_BITWIDTH'(1);
        len_eff   = (cfg_len == '0) ? CNT_BITWIDTH'(1) : cfg_len;
    end

`ifdef PSUM_SAT_EN
    // Sticky saturation indicator is only exposed with the result
    always_comb begin
        sat_flag = (state_q == HOLD) && sat_q;
    end
`endif

    // Next-state for group sequencing and accumulation
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
`ifdef PSUM_SAT_EN
        sat_d   = sat_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = in_data;
                    cnt_d = CNT_BITWIDTH'(1);
                    len_d = len_eff;
`ifdef PSUM_SAT_EN
                    sat_d = 1'b0;
`endif
                    if (len_eff == CNT_BITWIDTH'(1)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
`ifdef PSUM_SAT_EN
                    sat_d = sat_q || ovf;
`endif
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any partial group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= CNT_BITWIDTH'(1);
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

`ifdef PSUM_SAT_EN
    // Sticky saturation register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`endif

endmodule

// File: doc/psum_acc.md
# psum_acc

Sequential partial-sum accumulator that consumes a stream of DATA_BITWIDTH-wide sums and reduces every cfg_len consecutive beats into one result. It sits downstream of the combinational two-input adders in the PE datapath. Its job is to turn their per-cycle outputs into finished partial sums, delivered to the global buffer write port over a valid/ready handshake.

## Interface
- DATA_BITWIDTH, 16, width of input terms and the result (two's complement).
- CNT_BITWIDTH, 8, width of the term counter and of cfg_len.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_len  input  CNT_BITWIDTH  number of terms per result; sampled only on the first accepted beat of a group; 0 is treated as 1.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_BITWIDTH  term to accumulate.
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_BITWIDTH  accumulated result.
- busy  output  1  high while a group is in progress or a result is held (state != IDLE).
- sat_flag  output  1  present only with PSUM_SAT_EN; high with out_valid if any add in the group saturated.

## Operation
- Beat accept: in_valid && in_ready at a rising edge.
- States: IDLE, ACC, HOLD.
  - IDLE: in_ready=1. On accept: acc<=in_data; cnt<=1; len_q<=max(cfg_len,1). If len_q==1, go to HOLD; otherwise go to ACC.
  - ACC: in_ready=1. On accept: acc<=acc+in_data; cnt<=cnt+1. If cnt+1==len_q, go to HOLD. No accept means all state is held.
  - HOLD: in_ready=0, out_valid=1, out_data=acc. On out_ready, go to IDLE; acc and cnt are left as-is until the next group.
- Sums are always computed through a single adder2 instance.
- Arithmetic without the macro: wrap modulo 2^DATA_BITWIDTH.
- in_data changing while in_valid=0 has no effect.
- cfg_len changing mid-group has no effect.
- out_data is stable while out_valid && !out_ready.
- Reset mid-group: the partial group is discarded immediately and nothing is emitted for it.

## Timing
- Reset values:
  - state=IDLE, acc=0, cnt=0, len_q=1.
  - out_valid=0, out_data=0, busy=0, in_ready=1.
  - sat_flag=0 when the macro is compiled in.
- Latency: out_valid rises the cycle after the last beat of a group is accepted.
- Throughput: one term per cycle. Each group costs at least one HOLD cycle with in_ready=0; there is no accept in the same cycle the result leaves.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- PSUM_SAT_EN defined:
  - Each add is signed-saturating: positive overflow gives 2^(DW-1)-1 and negative overflow gives -2^(DW-1).
  - An internal sticky flag is cleared on the first beat of a group and set on any saturating add.
  - The sticky flag drives sat_flag in HOLD; sat_flag is 0 elsewhere.
- PSUM_SAT_EN undefined:
  - Wrap-around arithmetic.
  - The sat_flag port does not exist.

## Structure
- Shared package psum_pkg holds:
  - the state enum (IDLE, ACC, HOLD);
  - constants SAT_MAX and SAT_MIN, derived from DATA_BITWIDTH.
- Sub-module: one adder2 instance (left=acc, right=in_data).
  - Overflow detection and the saturation mux wrap its output inside psum_acc.

## Test plan
- Basic group: cfg_len=4, in_data 1, 2, 3, 4 back-to-back, out_ready=1 → out_data=10 and out_valid for one cycle, 1 cycle after the 4th accept.
- Degenerate length: cfg_len=0, in_data=7 → out_data=7 after one beat, identical to cfg_len=1.
- Backpressure: cfg_len=2, data 5 and 6, out_ready=0 for 5 cycles → out_data=11 held stable, in_ready=0 throughout, then released on out_ready.
- Wrap and saturation, DW=16, cfg_len=2, data 0x7FFF and 0x0001:
  - without PSUM_SAT_EN → 0x8000;
  - with PSUM_SAT_EN → 0x7FFF and sat_flag=1.
  - A following group of 1 and 1 → 2 with sat_flag=0.
- Reset mid-group: cfg_len=3, accept 2 beats, pull rst_n low asynchronously → out_valid=0, busy=0 immediately. A fresh group of 1, 1, 1 then yields 3.
- Bubbles: cfg_len=3, in_valid toggled 1, 0, 1, 0, 1 with data 4, X, 5, X, 6 → out_data=15, and the X values are ignored.
